// File: rtl/led_pkg.sv
// Shared types and the code-to-LED decode used by the status LED driver.
package led_pkg;

  typedef enum logic [1:0] {
    STEADY = 2'd0,
    BLINK  = 2'd1,
    OFF    = 2'd2,
    TEST   = 2'd3
  } led_mode_t;

  // FREE: a new status may be loaded; HOLD: the displayed code is pinned.
  typedef enum logic {
    FREE = 1'b0,
    HOLD = 1'b1
  } hold_state_t;

  // Widest LED bank the decode function can describe (STATUS_W up to 8).
  localparam int unsigned LED_MAX_W = 255;

  // Code 0 -> no LED; code k -> only bit k-1, limited to 'width' LEDs.
  function automatic logic [LED_MAX_W-1:0] onehot_led(input int unsigned code,
                                                      input int unsigned width);
    logic [LED_MAX_W-1:0] pat;
    pat = '0;
    for (int unsigned i = 0; i < LED_MAX_W; i++) begin
      if ((i + 1 == code) && (i < width)) pat[i] = 1'b1;
    end
    return pat;
  endfunction

endpackage

// File: rtl/blink_timer.sv
// Free-running blink phase generator with a synchronous restart.
// phase starts high and toggles every BLINK_DIV cycles; 'wrap' flags the
// cycle on which the next edge will toggle it.
module blink_timer #(
  parameter int unsigned BLINK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic phase,
  output logic wrap
);

  localparam int unsigned CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             phase_q, phase_d;

  // Next count/phase: restart wins, otherwise count and toggle on wrap.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (restart) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (blink_cnt_q == CNT_MAX) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end
  end

  // Counter and phase registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign phase = phase_q;
  assign wrap  = (blink_cnt_q == CNT_MAX);

endmodule

// File: rtl/status_led_driver.sv
// Drives a one-hot LED bank from a controller status code, with display
// modes, a minimum-hold stretcher and a one-cycle change strobe.
// LED and changed come straight from flops, computed from next-state values
// so a load or mode change is visible right after the edge that samples it.
module status_led_driver
  import led_pkg::*;
#(
  parameter int unsigned STATUS_W    = 2,
  parameter int unsigned BLINK_DIV   = 50_000_000,
  parameter int unsigned HOLD_CYCLES = 25_000_000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [STATUS_W-1:0]        status,
  input  logic [1:0]                 mode,
  output logic [(2**STATUS_W)-2:0]   LED,
  output logic                       changed
);

  localparam int unsigned LED_W  = (2 ** STATUS_W) - 1;
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

  logic [STATUS_W-1:0] disp_q, disp_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [LED_W-1:0]    led_q, led_d;
  logic                changed_q, changed_d;
  hold_state_t         state;
  logic                load;
  logic                phase, wrap, phase_nxt;
  logic [LED_W-1:0]    pattern;
  led_mode_t           mode_e;

  blink_timer #(
    .BLINK_DIV (BLINK_DIV)
  ) u_blink (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (load),
    .phase   (phase),
    .wrap    (wrap)
  );

  // Hold FSM: state is implied by the hold counter; loads only when FREE.
  always_comb begin
    state      = (hold_cnt_q == '0) ? FREE : HOLD;
    disp_d     = disp_q;
    hold_cnt_d = hold_cnt_q;
    load       = 1'b0;
    case (state)
      FREE: begin
        if (status != disp_q) begin
          load       = 1'b1;
          disp_d     = status;
          hold_cnt_d = HOLD_LOAD;
        end
      end
      HOLD: begin
        hold_cnt_d = hold_cnt_q - 1'b1;
      end
      default: begin
        hold_cnt_d = '0;
      end
    endcase
  end

  // Output decode from next-state display code, blink phase and mode.
  always_comb begin
    phase_nxt = load ? 1'b1 : (phase ^ wrap);
    pattern   = LED_W'(onehot_led(32'(disp_d), LED_W));
    mode_e    = led_mode_t'(mode);
    changed_d = load;
    case (mode_e)
      STEADY:  led_d = pattern;
      BLINK:   led_d = phase_nxt ? pattern : '0;
      OFF:     led_d = '0;
      TEST:    led_d = '1;
      default: led_d = '0;
    endcase
  end

  // Display, hold and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      disp_q     <= '0;
      hold_cnt_q <= '0;
      led_q      <= '0;
      changed_q  <= 1'b0;
    end else begin
      disp_q     <= disp_d;
      hold_cnt_q <= hold_cnt_d;
      led_q      <= led_d;
      changed_q  <= changed_d;
    end
  end

  assign LED     = led_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_status_led_driver.sv
// Bench for status_led_driver: two instances (hold 8 and hold 0) checked
// every cycle against a cycle-count reference model plus directed checks.
module tb_status_led_driver;

  localparam int BDIV = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] st_a = 2'd0, st_b = 2'd0;
  logic [1:0] md_a = 2'd0, md_b = 2'd0;
  logic [2:0] led_a, led_b;
  logic       chg_a, chg_b;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state: [0] = hold 8, [1] = hold 0
  int         hold_p [2] = '{8, 0};
  int         m_disp [2];
  int         m_rem  [2];
  int         m_t    [2];
  logic [2:0] m_led  [2];
  logic       m_chg  [2];

  always #5 clk = ~clk;

  status_led_driver #(.STATUS_W(2), .BLINK_DIV(BDIV), .HOLD_CYCLES(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .status(st_a), .mode(md_a),
    .LED(led_a), .changed(chg_a));

  status_led_driver #(.STATUS_W(2), .BLINK_DIV(BDIV), .HOLD_CYCLES(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .status(st_b), .mode(md_b),
    .LED(led_b), .changed(chg_b));

  function automatic logic [2:0] exp_led(int d, int t, logic [1:0] m);
    logic [2:0] p;
    logic       on;
    p  = (d == 0) ? 3'b000 : 3'(1 << (d - 1));
    on = ((t / BDIV) % 2) == 0;
    case (m)
      2'd0:    return p;
      2'd1:    return on ? p : 3'b000;
      2'd2:    return 3'b000;
      default: return 3'b111;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_disp[i] = 0; m_rem[i] = 0; m_t[i] = 0; m_led[i] = 3'b000; m_chg[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input int i, input int s, input logic [1:0] m);
    if (m_rem[i] == 0 && s != m_disp[i]) begin
      m_disp[i] = s; m_rem[i] = hold_p[i]; m_t[i] = 0; m_chg[i] = 1'b1;
    end else begin
      if (m_rem[i] > 0) m_rem[i] = m_rem[i] - 1;
      m_t[i] = m_t[i] + 1;
      m_chg[i] = 1'b0;
    end
    m_led[i] = exp_led(m_disp[i], m_t[i], m_md(m));
  endtask

  function automatic logic [1:0] m_md(logic [1:0] m);
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("model_led_a", 32'(led_a), 32'(m_led[0]));
    chk("model_chg_a", 32'(chg_a), 32'(m_chg[0]));
    chk("model_led_b", 32'(led_b), 32'(m_led[1]));
    chk("model_chg_b", 32'(chg_b), 32'(m_chg[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) begin
      model_edge(0, int'(st_a), md_a);
      model_edge(1, int'(st_b), md_b);
    end else begin
      model_reset();
    end
    #1;
    check_model();
  endtask

  task automatic set_in(input logic [1:0] s, input logic [1:0] m);
    st_a = s; st_b = s; md_a = m; md_b = m;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n001, npulse, bad;
    bit seen010;

    // reset
    model_reset();
    set_in(2'd0, 2'd0);
    repeat (3) tick();
    chk("reset_led", 32'(led_a), 32'h0);
    chk("reset_chg", 32'(chg_a), 32'h0);
    reset_n = 1'b1;

    // steady sweep 0..3
    for (int s = 0; s < 4; s++) begin
      set_in(2'(s), 2'd0);
      repeat (20) tick();
      chk("steady_led", 32'(led_a), (s == 0) ? 32'h0 : 32'(1 << (s - 1)));
    end

    // short glitch code held for load + 8 cycles, then next code
    set_in(2'd1, 2'd0);
    tick();
    n001 = (led_a == 3'b001) ? 1 : 0;
    npulse = chg_a ? 1 : 0;
    bad = 0; seen010 = 1'b0;
    set_in(2'd2, 2'd0);
    for (int k = 0; k < 20; k++) begin
      tick();
      if (led_a == 3'b001) begin
        n001++;
        if (seen010) bad++;
      end
      if (led_a == 3'b010) seen010 = 1'b1;
      if (chg_a) npulse++;
    end
    chk("hold_len", 32'(n001), 32'd9);
    chk("hold_pulses", 32'(npulse), 32'd2);
    chk("no_glitch_return", 32'(bad), 32'd0);

    // hold disabled: toggling status followed every cycle
    for (int k = 0; k < 10; k++) begin
      st_b = (k % 2) ? 2'd3 : 2'd1;
      tick();
      chk("tog_led_b", 32'(led_b), (k % 2) ? 32'h4 : 32'h1);
      chk("tog_chg_b", 32'(chg_b), 32'h1);
    end

    // blink: 4 on / 4 off, then a load in the off phase restarts on-phase
    set_in(2'd1, 2'd0);
    repeat (20) tick();
    set_in(2'd2, 2'd1);
    for (int k = 0; k < 14; k++) begin
      tick();
      chk("blink_2", 32'(led_a), ((k / 4) % 2 == 0) ? 32'h2 : 32'h0);
    end
    set_in(2'd3, 2'd1);
    tick();
    chk("blink_load_led", 32'(led_a), 32'h4);
    chk("blink_load_chg", 32'(chg_a), 32'h1);
    for (int k = 1; k < 8; k++) begin
      tick();
      chk("blink_3", 32'(led_a), ((k / 4) % 2 == 0) ? 32'h4 : 32'h0);
    end

    // mode changes: TEST, OFF, back to STEADY without a change pulse
    set_in(2'd1, 2'd0);
    repeat (20) tick();
    md_a = 2'd3; md_b = 2'd3;
    tick();
    chk("mode_test", 32'(led_a), 32'h7);
    md_a = 2'd2; md_b = 2'd2;
    tick();
    chk("mode_off", 32'(led_a), 32'h0);
    md_a = 2'd0; md_b = 2'd0;
    tick();
    chk("mode_steady", 32'(led_a), 32'h1);
    chk("mode_steady_chg", 32'(chg_a), 32'h0);

    // asynchronous reset in the middle of a hold
    set_in(2'd3, 2'd0);
    tick();
    repeat (3) tick();
    chk("pre_reset_led", 32'(led_a), 32'h4);
    set_in(2'd2, 2'd0);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_led", 32'(led_a), 32'h0);
    chk("async_rst_chg", 32'(chg_a), 32'h0);
    chk("async_rst_led_b", 32'(led_b), 32'h0);
    tick();
    reset_n = 1'b1;
    set_in(2'd3, 2'd0);
    tick();
    chk("post_rst_led", 32'(led_a), 32'h4);
    chk("post_rst_chg", 32'(chg_a), 32'h1);

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) st_a = 2'($urandom_range(0, 3));
      st_b = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) md_a = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) md_b = 2'($urandom_range(0, 3));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/status_led_driver.md
# status_led_driver

Parametrised status-to-LED indicator driving a board LED bank from an FSM status code. Code 0 lights nothing; code k lights only LED[k-1]. Adds display modes (steady, blink, off, lamp test), a minimum-hold stretcher so short-lived states stay visible, and a change-strobe. Sits between a controller FSM's status output and the top-level LED pins.

## Interface
Parameters:
- STATUS_W, 2: width of status code; LED_W = 2**STATUS_W − 1 (derived localparam, not overridable).
- BLINK_DIV, 50_000_000: blink half-period in clk cycles; ≥ 1.
- HOLD_CYCLES, 25_000_000: minimum cycles a displayed code is held; 0 disables hold.

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- status  in  STATUS_W  status code from the controlling FSM; synchronous to clk.
- mode  in  2  display mode: 0 STEADY, 1 BLINK, 2 OFF, 3 TEST.
- LED  out  LED_W  registered LED drive, bit k−1 ↔ code k.
- changed  out  1  one-cycle pulse when the displayed code is updated.

## Operation
- Internal registers: disp (displayed code), hold_cnt, blink_cnt, phase.
- Reset values: disp=0, LED=0, changed=0, hold_cnt=0 (hold expired), blink_cnt=0, phase=1.
- Hold FSM, two states: FREE (hold_cnt==0) and HOLD (hold_cnt>0).
  - FREE and status≠disp: load disp←status, hold_cnt←HOLD_CYCLES, changed=1, blink_cnt←0, phase←1.
  - FREE and status==disp: nothing; changed=0.
  - HOLD: hold_cnt decrements by 1 per cycle; status is ignored; changed=0.
  - HOLD→FREE when hold_cnt reaches 0; the status present in the first FREE cycle is compared. Intermediate codes seen during HOLD are dropped, never queued.
  - HOLD_CYCLES=0: block never enters HOLD; every differing status loads immediately.
- Decode: pattern = 0 for disp=0, else one-hot with bit disp−1 set.
- LED by mode: STEADY → pattern; BLINK → pattern when phase=1, else 0; OFF → 0; TEST → all ones.
- Blink timer runs in all modes; blink_cnt counts 0..BLINK_DIV−1, phase toggles on wrap. Restarts (phase=1) on every disp load so a new state shows immediately.
- Mode changes take effect with no restart of the hold or blink timers; the hold stretcher operates independently of mode.
- Counter widths: $clog2(HOLD_CYCLES+1) and $clog2(BLINK_DIV), minimum 1 bit; no overflow possible.

## Timing
- Latency: status change sampled at edge k (FREE) → disp, LED, changed all valid after edge k; changed deasserts after edge k+1.
- Mode change sampled at edge k → LED reflects new mode after edge k.
- Status changing at the same edge hold_cnt reaches 0: not loaded that edge; loaded next edge if still different.
- Status returning to disp during HOLD: no change, no pulse.
- Reset asserted mid-hold or mid-blink: all registers return to reset values immediately (asynchronous); first edge after deassertion behaves as FREE with disp=0.
- LED is glitch-free: driven only from flops.

## Structure
- Package led_pkg: enum led_mode_t {STEADY, BLINK, OFF, TEST} (2-bit), function onehot_led(code) returning the decode pattern, parameterised via width argument.
- Sub-module blink_timer (params BLINK_DIV; ports clk, reset_n, restart, phase) holds blink_cnt/phase; hold FSM, decode and output register stay in status_led_driver.

## Test plan
Use STATUS_W=2, BLINK_DIV=4, HOLD_CYCLES=8.
- Reset then status=0..3 each held 20 cycles, mode STEADY → LED 000, 001, 010, 100; changed one pulse per transition, one cycle after edge.
- status 1 for 1 cycle then 2, mode STEADY → LED=001 for exactly 9 cycles (load + 8 hold), then 010; changed pulses twice; glitch code never reappears.
- HOLD_CYCLES=0, status toggles 1/3 every cycle → LED follows with 1-cycle latency, changed high every cycle.
- mode BLINK, status=2 → LED alternates 010 for 4 cycles / 000 for 4 cycles; status→3 mid-off-phase → LED=100 on the next edge, restart of on-phase.
- mode TEST then OFF with status=1 → LED=111 then 000; switch back to STEADY → 001 without changed pulse.
- reset_n low asynchronously mid-hold with LED=100 → LED=000, changed=0 before next clk edge; after release status=3 loads on first edge.
